// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage. Holds the PC and issues one request/ack read per
// instruction. It then hands {inst, inst_pc, next_instaddress} to decode under
// a valid/ready handshake. Taken jumps, jr and branches reported by decode
// take effect after exactly one MIPS delay slot.
//
// States
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | one dead cycle after reset, no request
//   REQ   | inst_req high, inst_addr = pc, waiting for inst_ack
//   HOLD  | instruction presented to decode (inst_valid), waiting for accept
//
// Ports
//   clk               in   1   clock, all state on the rising edge
//   rst               in   1   synchronous, active-high reset
//   inst_req          out  1   read request to instruction memory
//   inst_addr         out  32  address of the outstanding request
//   inst_ack          in   1   read data valid, completes the request
//   inst_rdata        in   32  instruction word, qualified by inst_ack
//   inst              out  32  instruction presented to decode
//   inst_pc           out  32  address of inst
//   next_instaddress  out  32  inst_pc + 4
//   inst_valid        out  1   inst / inst_pc / next_instaddress valid
//   inst_ready        in   1   decode accepts (accept = inst_valid & inst_ready)
//   redirect          in   1   accepted inst is a taken jump/jr/branch
//   redirect_target   in   32  redirect destination, sampled on accept
//   fetch_adel        out  1   current fetch came from a misaligned target
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,

    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,

    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] next_instaddress,
    output logic        inst_valid,
    input  logic        inst_ready,

    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        fetch_adel
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tgt_pend;
    logic        in_ds;
    logic        accept;

    // Decode only acknowledges while we are actually presenting something.
    assign accept    = (state == S_HOLD) && inst_valid && inst_ready;

    // pc is held constant for the whole REQ phase, so it doubles as the
    // request address without needing a separate register.
    assign inst_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            pc               <= RESET_PC;
            tgt              <= 32'h0;
            tgt_pend         <= 1'b0;
            in_ds            <= 1'b0;
            inst_req         <= 1'b0;
            inst_valid       <= 1'b0;
            inst             <= 32'h0;
            inst_pc          <= 32'h0;
            next_instaddress <= 32'h0;
            fetch_adel       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    inst_req <= 1'b1;
                end

                S_REQ: begin
                    if (inst_ack) begin
                        inst             <= inst_rdata;
                        inst_pc          <= pc;
                        next_instaddress <= pc + 32'd4;
                        inst_valid       <= 1'b1;
                        inst_req         <= 1'b0;
                        state            <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (accept) begin
                        inst_valid <= 1'b0;
                        inst_req   <= 1'b1;
                        state      <= S_REQ;
                        if (redirect && !in_ds) begin
                            // Taken control transfer: fetch the delay slot
                            // first and park the target until it is accepted.
                            tgt        <= redirect_target;
                            tgt_pend   <= 1'b1;
                            in_ds      <= 1'b1;
                            pc         <= next_instaddress;
                            fetch_adel <= 1'b0;
                        end else if (tgt_pend) begin
                            // Delay slot accepted: jump. A misaligned target
                            // is fetched word-aligned and flagged so the
                            // exception travels with that instruction.
                            pc         <= {tgt[31:2], 2'b00};
                            fetch_adel <= |tgt[1:0];
                            tgt_pend   <= 1'b0;
                            in_ds      <= 1'b0;
                        end else begin
                            pc         <= next_instaddress;
                            fetch_adel <= 1'b0;
                            in_ds      <= 1'b0;
                        end
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    inst_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] next_instaddress;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        fetch_adel;

    int vecs = 0;
    int errs = 0;

    inst_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .inst_req         (inst_req),
        .inst_addr        (inst_addr),
        .inst_ack         (inst_ack),
        .inst_rdata       (inst_rdata),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .next_instaddress (next_instaddress),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .redirect         (redirect),
        .redirect_target  (redirect_target),
        .fetch_adel       (fetch_adel)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Serve one request: wait (bounded) for inst_req, hold off ack for
    // 'delay' cycles, then ack with rdata. Returns the address seen and
    // whether req/addr stayed stable while waiting.
    task automatic do_fetch(input int delay, input logic [31:0] rdata,
                            output logic [31:0] addr, output logic stable);
        int n;
        n = 0;
        while (!inst_req && n < 20) begin
            step();
            n++;
        end
        vecs++;
        if (inst_req !== 1'b1) begin
            errs++;
            $display("FAIL req_timeout: inst_req=%b required 1", inst_req);
        end
        addr   = inst_addr;
        stable = 1'b1;
        for (int i = 0; i < delay; i++) begin
            step();
            if (inst_req !== 1'b1 || inst_addr !== addr || inst_valid !== 1'b0)
                stable = 1'b0;
        end
        inst_ack   = 1'b1;
        inst_rdata = rdata;
        step();
        inst_ack   = 1'b0;
        inst_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic do_accept(input logic redir, input logic [31:0] target);
        inst_ready      = 1'b1;
        redirect        = redir;
        redirect_target = target;
        step();
        inst_ready      = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h1234_5677;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vecs++;
        if (inst_req !== 1'b0 || inst_valid !== 1'b0 || fetch_adel !== 1'b0) begin
            errs++;
            $display("FAIL reset_ctl: req=%b valid=%b adel=%b required 0 0 0",
                     inst_req, inst_valid, fetch_adel);
        end
        vecs++;
        if (inst !== 32'h0 || inst_pc !== 32'h0 || next_instaddress !== 32'h0) begin
            errs++;
            $display("FAIL reset_data: inst=%h pc=%h nia=%h required 0 0 0",
                     inst, inst_pc, next_instaddress);
        end
        rst = 1'b0;
        step();
        vecs++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0000) begin
            errs++;
            $display("FAIL reset_first_req: req=%b addr=%h required 1 bfc00000",
                     inst_req, inst_addr);
        end
    endtask

    task automatic test_basic();
        logic [31:0] a;
        logic        s;
        logic [31:0] exp_addr [3];
        exp_addr[0] = 32'hBFC0_0000;
        exp_addr[1] = 32'hBFC0_0004;
        exp_addr[2] = 32'hBFC0_0008;
        for (int i = 0; i < 3; i++) begin
            do_fetch(0, 32'hA000_0000 + i, a, s);
            vecs++;
            if (a !== exp_addr[i]) begin
                errs++;
                $display("FAIL basic_addr%0d: got %h required %h", i, a, exp_addr[i]);
            end
            vecs++;
            if (inst_valid !== 1'b1 || inst_req !== 1'b0 || inst !== 32'hA000_0000 + i) begin
                errs++;
                $display("FAIL basic_hold%0d: valid=%b req=%b inst=%h required 1 0 %h",
                         i, inst_valid, inst_req, inst, 32'hA000_0000 + i);
            end
            vecs++;
            if (inst_pc !== exp_addr[i] || next_instaddress !== exp_addr[i] + 32'd4) begin
                errs++;
                $display("FAIL basic_pc%0d: pc=%h nia=%h required %h %h",
                         i, inst_pc, next_instaddress, exp_addr[i], exp_addr[i] + 32'd4);
            end
            do_accept(1'b0, 32'h0);
            vecs++;
            if (inst_valid !== 1'b0) begin
                errs++;
                $display("FAIL basic_valid_drop%0d: valid=%b required 0", i, inst_valid);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        logic        s;
        do_fetch(3, 32'h1111_2222, a, s);
        vecs++;
        if (a !== 32'hBFC0_000C || s !== 1'b1) begin
            errs++;
            $display("FAIL stall_req: addr=%h stable=%b required bfc0000c 1", a, s);
        end
        for (int i = 0; i < 4; i++) begin
            // noise on unrelated inputs while held: stray ack and unaccepted redirect
            inst_ack        = (i == 1);
            inst_rdata      = 32'hFFFF_0000;
            redirect        = (i == 2);
            redirect_target = 32'h8000_0F00;
            step();
            vecs++;
            if (inst !== 32'h1111_2222 || inst_pc !== 32'hBFC0_000C ||
                inst_valid !== 1'b1 || inst_req !== 1'b0) begin
                errs++;
                $display("FAIL stall_hold%0d: inst=%h pc=%h valid=%b req=%b required 11112222 bfc0000c 1 0",
                         i, inst, inst_pc, inst_valid, inst_req);
            end
        end
        inst_ack = 1'b0;
        redirect = 1'b0;
        do_accept(1'b0, 32'h0);
        vecs++;
        if (inst_addr !== 32'hBFC0_0010) begin
            errs++;
            $display("FAIL stall_next: addr=%h required bfc00010", inst_addr);
        end
    endtask

    task automatic test_redirect();
        logic [31:0] a;
        logic        s;
        do_fetch(0, 32'h1000_0040, a, s);
        do_accept(1'b1, 32'h8000_0100);
        do_fetch(1, 32'h0000_0000, a, s);
        vecs++;
        if (a !== 32'hBFC0_0014) begin
            errs++;
            $display("FAIL redir_ds_addr: got %h required bfc00014", a);
        end
        do_accept(1'b1, 32'h8000_0200);   // must be ignored: delay slot
        do_fetch(0, 32'h2400_0001, a, s);
        vecs++;
        if (a !== 32'h8000_0100 || fetch_adel !== 1'b0) begin
            errs++;
            $display("FAIL redir_tgt: addr=%h adel=%b required 80000100 0", a, fetch_adel);
        end
        do_accept(1'b0, 32'h0);
        do_fetch(0, 32'h2400_0002, a, s);
        vecs++;
        if (a !== 32'h8000_0104) begin
            errs++;
            $display("FAIL redir_after: got %h required 80000104", a);
        end
        do_accept(1'b0, 32'h0);
    endtask

    task automatic test_misaligned();
        logic [31:0] a;
        logic        s;
        do_fetch(0, 32'h0800_0040, a, s);      // 80000108
        do_accept(1'b1, 32'h8000_0102);
        do_fetch(0, 32'h0, a, s);              // 8000010C delay slot
        vecs++;
        if (a !== 32'h8000_010C || fetch_adel !== 1'b0) begin
            errs++;
            $display("FAIL adel_ds: addr=%h adel=%b required 8000010c 0", a, fetch_adel);
        end
        do_accept(1'b0, 32'h0);
        vecs++;
        if (inst_addr !== 32'h8000_0100 || fetch_adel !== 1'b1) begin
            errs++;
            $display("FAIL adel_req: addr=%h adel=%b required 80000100 1", inst_addr, fetch_adel);
        end
        do_fetch(2, 32'h3C00_0000, a, s);
        vecs++;
        if (inst_pc !== 32'h8000_0100 || fetch_adel !== 1'b1) begin
            errs++;
            $display("FAIL adel_hold: pc=%h adel=%b required 80000100 1", inst_pc, fetch_adel);
        end
        do_accept(1'b0, 32'h0);
        do_fetch(0, 32'h3C00_0001, a, s);
        vecs++;
        if (a !== 32'h8000_0104 || fetch_adel !== 1'b0) begin
            errs++;
            $display("FAIL adel_clear: addr=%h adel=%b required 80000104 0", a, fetch_adel);
        end
        do_accept(1'b0, 32'h0);
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        logic        s;
        do_fetch(0, 32'h0, a, s);              // 80000108
        do_accept(1'b1, 32'hFFFF_FFFC);
        do_fetch(0, 32'h0, a, s);              // 8000010C delay slot
        do_accept(1'b0, 32'h0);
        do_fetch(0, 32'h5555_AAAA, a, s);
        vecs++;
        if (a !== 32'hFFFF_FFFC || next_instaddress !== 32'h0) begin
            errs++;
            $display("FAIL wrap_top: addr=%h nia=%h required fffffffc 00000000", a, next_instaddress);
        end
        do_accept(1'b0, 32'h0);
        vecs++;
        if (inst_addr !== 32'h0 || inst_req !== 1'b1) begin
            errs++;
            $display("FAIL wrap_zero: addr=%h req=%b required 00000000 1", inst_addr, inst_req);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        logic        s;
        vecs++;
        if (inst_req !== 1'b1) begin
            errs++;
            $display("FAIL rstmid_pre: req=%b required 1", inst_req);
        end
        rst = 1'b1;
        step();
        rst        = 1'b0;
        inst_ack   = 1'b1;
        inst_rdata = 32'hBAD0_BAD0;
        vecs++;
        if (inst_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            errs++;
            $display("FAIL rstmid_vals: req=%b valid=%b inst=%h pc=%h required 0 0 0 0",
                     inst_req, inst_valid, inst, inst_pc);
        end
        step();
        inst_ack = 1'b0;
        vecs++;
        if (inst_req !== 1'b1 || inst_valid !== 1'b0 || inst !== 32'h0 ||
            inst_addr !== 32'hBFC0_0000) begin
            errs++;
            $display("FAIL rstmid_ack_ignored: req=%b valid=%b inst=%h addr=%h required 1 0 0 bfc00000",
                     inst_req, inst_valid, inst, inst_addr);
        end
        do_fetch(0, 32'h7777_0001, a, s);
        vecs++;
        if (inst !== 32'h7777_0001 || inst_pc !== 32'hBFC0_0000) begin
            errs++;
            $display("FAIL rstmid_refetch: inst=%h pc=%h required 77770001 bfc00000", inst, inst_pc);
        end
    endtask

    initial begin
        rst             = 1'b1;
        inst_ack        = 1'b0;
        inst_rdata      = 32'hDEAD_BEEF;
        inst_ready      = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
